// File: rtl/nibble_serial_alu_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nsa_state_t;

  localparam logic [4:0]  ALU_A_MINUS_B = 5'b01001;
  localparam int unsigned NIBW          = 4;

endpackage

// File: rtl/mc10181.sv
// Combinational 4-bit ALU slice; bit 0 is the MSB, carry is active-high.
module mc10181 (
  input  logic [0:3] S,
  input  logic       M,
  input  logic [0:3] A,
  input  logic [0:3] B,
  input  logic       CIN,
  output logic [0:3] F,
  output logic       COUT
);

  logic g;
  logic p;
  logic c;

  always_comb begin
    g = 1'b0;
    p = 1'b0;
    c = CIN;
    F = '0;
    // Ripple from bit 3 (LSB) up to bit 0 (MSB); M=1 suppresses the carry for logic ops.
    for (int unsigned j = 0; j < 4; j++) begin
      g        = A[3-j] & ~(B[3-j] ? S[3] : S[2]);
      p        = A[3-j] | ~(B[3-j] ? S[0] : S[1]);
      F[3-j]   = (p & ~g) ^ (c & ~M);
      c        = g | (p & c);
    end
    COUT = c;
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Runs a WIDTH-bit ALU operation through one external 4-bit slice, one nibble per clock,
// rippling the slice carry through a flop and assembling the full result.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic             cin,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] result,
  output logic             cout,
  output logic [0:3]       sliceA,
  output logic [0:3]       sliceB,
  output logic [0:3]       sliceS,
  output logic             sliceM,
  output logic             sliceCIN,
  input  logic [0:3]       sliceF,
  input  logic             sliceCOUT
);

  localparam int unsigned NIB = WIDTH / NIBW;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  nsa_state_t       state_q,  state_d;
  logic [CW-1:0]    k_q,      k_d;
  logic [0:WIDTH-1] a_q,      a_d;
  logic [0:WIDTH-1] b_q,      b_d;
  logic [4:0]       op_q,     op_d;
  logic             carry_q,  carry_d;
  logic [0:WIDTH-1] result_q, result_d;
  int unsigned      base;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    sliceA   = '0;
    sliceB   = '0;
    sliceCIN = 1'b0;
    // Nibble k=0 is the least-significant one, i.e. the highest bit indices.
    base     = (NIB - 1 - 32'(k_q)) * NIBW;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = cin;
          k_d     = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sliceA                 = a_q[base +: NIBW];
        sliceB                 = b_q[base +: NIBW];
        sliceCIN               = carry_q;
        result_d[base +: NIBW] = sliceF;
        carry_d                = sliceCOUT;
        if (k_q == CW'(NIB - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = carry_q;
  assign sliceS = op_q[3:0];
  assign sliceM = op_q[4];

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed and random checks of nibble_serial_alu driving an mc10181 slice.
module tb_nibble_serial_alu;
  import alu_pkg::*;

  localparam int unsigned W = 36;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [4:0]   op;
  logic [0:W-1] a, b, result;
  logic         busy, done, cout;
  logic [0:3]   sliceA, sliceB, sliceS, sliceF;
  logic         sliceM, sliceCIN, sliceCOUT;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .sliceA(sliceA), .sliceB(sliceB), .sliceS(sliceS), .sliceM(sliceM),
    .sliceCIN(sliceCIN), .sliceF(sliceF), .sliceCOUT(sliceCOUT)
  );

  mc10181 slice (
    .S(sliceS), .M(sliceM), .A(sliceA), .B(sliceB), .CIN(sliceCIN),
    .F(sliceF), .COUT(sliceCOUT)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic push);
    exp_t e;
    a     = ta;
    b     = tb_v;
    op    = ALU_A_MINUS_B;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (push) begin
      e.r = ta - tb_v;
      e.c = (ta >= tb_v);
      sb.push_back(e);
    end
  endtask

  // Waits (bounded) for done, checking latency and busy length, then scores the result.
  task automatic wait_done(input string tag, input int exp_n);
    int   n;
    int   nbusy;
    exp_t e;
    n     = 0;
    nbusy = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nbusy++;
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_n));
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_n));
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, 64'(result), 64'(e.r));
      check({tag, "_cout"}, 64'(cout), 64'(e.c));
    end else begin
      check({tag, "_done_seen"}, 64'(done), 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           ndone;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout",   64'(cout),   64'd0);
    check("rst_sliceS", 64'(sliceS), 64'd0);
    check("rst_sliceA", 64'(sliceA), 64'd0);

    // Simple subtract 5 - 3
    issue(36'd5, 36'd3, 1'b1);
    check("sub_sliceA_n0", 64'(sliceA), 64'h5);
    check("sub_sliceB_n0", 64'(sliceB), 64'h3);
    check("sub_sliceS",    64'(sliceS), 64'b1001);
    check("sub_sliceM",    64'(sliceM), 64'd0);
    check("sub_sliceCIN",  64'(sliceCIN), 64'd1);
    wait_done("sub", 9);
    check("sub_idle_sliceA",   64'(sliceA),   64'd0);
    check("sub_idle_sliceCIN", 64'(sliceCIN), 64'd0);
    check("sub_idle_sliceS",   64'(sliceS),   64'b1001);
    tick();
    check("sub_done_pulse", 64'(done), 64'd0);
    check("sub_hold_result", 64'(result), 64'd2);

    // Borrow ripple across nibble 0 into nibble 1
    issue(36'h000000010, 36'd1, 1'b1);
    check("borrow_n0_sliceCOUT", 64'(sliceCOUT), 64'd0);
    tick();
    check("borrow_n1_sliceCIN", 64'(sliceCIN), 64'd0);
    check("borrow_n1_sliceA",   64'(sliceA),   64'h1);
    wait_done("borrow", 8);

    // Full wrap
    issue(36'd0, 36'd1, 1'b1);
    wait_done("wrap", 9);

    // Back-to-back: start during DONE accepted, start during RUN ignored
    issue(36'h123456789, 36'h023456780, 1'b1);
    wait_done("b2b_first", 9);
    issue(36'h000000100, 36'h000000200, 1'b1);
    check("b2b_busy_after_accept", 64'(busy), 64'd1);
    a     = 36'hFFFFFFFFF;
    b     = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b2b_second", 8);
    tick();
    check("b2b_no_extra_busy", 64'(busy), 64'd0);
    check("b2b_no_extra_done", 64'(done), 64'd0);

    // Reset in the middle of an operation
    issue(36'h00000FFFF, 36'h000000001, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_done",   64'(done),   64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_cout",   64'(cout),   64'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    issue(36'h0ABCDEF01, 36'h000000F02, 1'b1);
    wait_done("after_rst", 9);

    // Reset and start on the same edge: reset wins
    a     = 36'd7;
    b     = 36'd1;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);

    // Corners and random sweep
    issue(36'h5A5A5A5A5, 36'h5A5A5A5A5, 1'b1);
    wait_done("equal", 9);
    issue(36'hFFFFFFFFF, 36'd0, 1'b1);
    wait_done("max_minus_0", 9);
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      issue(ra, rb, 1'b1);
      wait_done("sweep", 9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu.md
# nibble_serial_alu

Sequencer that performs a full-width (default 36-bit) ALU operation by driving one external 4-bit `mc10181` slice one nibble per clock. It sits directly upstream of the slice: it presents operand nibbles, function select and carry-in, then captures `F`/`COUT` each cycle and ripples the carry through a flop. It assembles the full-width result and final carry-out for the data-path logic downstream.

## Interface
- `WIDTH`, 36, operand/result width; must be a multiple of 4.
- `NIB`, `WIDTH/4` (derived localparam), number of slice passes.

- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; takes effect at the posedge where it is sampled high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  5  `{M,S}` function code forwarded unmodified to the slice.
- `cin`  in  1  carry into the least-significant nibble.
- `a`, `b`  in  [0:WIDTH-1]  operands; bit 0 is the MSB.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `result`/`cout` are valid from this cycle on.
- `result`  out  [0:WIDTH-1]  assembled F nibbles.
- `cout`  out  1  COUT of the most-significant nibble.
- `sliceA`, `sliceB`  out  [0:3]  current operand nibble.
- `sliceS`  out  [0:3]  and `sliceM` out 1, driven from the latched `op`.
- `sliceCIN`  out  1  current carry into the slice.
- `sliceF`  in  [0:3]  slice result, combinational from the slice* outputs.
- `sliceCOUT`  in  1  slice carry-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with `start`=1:
  - Latch `a`, `b`, `op`, and `cin` into the carry flop.
  - Clear the nibble counter `k` to 0 and go to RUN.
- DONE with `start`=0 goes to IDLE.
- RUN, nibble k (k=0 is the least-significant nibble, bits `[WIDTH-4:WIDTH-1]`; k=NIB-1 is bits `[0:3]`):
  - Drive `sliceA`/`sliceB` with nibble k of the latched operands and `sliceCIN` with the carry flop.
  - On the posedge, write `sliceF` into result nibble k, load `sliceCOUT` into the carry flop, and increment k.
- After the k=NIB-1 capture, go to DONE. `cout` equals the carry flop.
- `start` is ignored while in RUN. There is no abort.
- Carry polarity is the slice's own convention; the block never inverts it.
- `result` and `cout` hold their value from DONE until the next `start` is accepted. They are not cleared on accept; they are overwritten nibble by nibble.
- Outside RUN:
  - `sliceA`, `sliceB` and `sliceCIN` are 0.
  - `sliceS`/`sliceM` show the latched `op`.
- Reset:
  - Returns to IDLE from any state, including mid-RUN (the partial result is discarded).
  - Clears `result`, `cout`, the carry flop, `k` and the latched `op`/operands to 0.
  - `busy`=0 and `done`=0.
- If `reset` and `start` are high on the same edge, reset wins.

## Timing
- `start` is sampled high at edge T0.
- RUN covers cycles T0+1 .. T0+NIB; `busy`=1 throughout.
- `done`=1 for exactly cycle T0+NIB+1 (T0+10 at default).
- Back-to-back: `start` high during the DONE cycle is accepted, and RUN resumes the next cycle. Throughput is one op per NIB+1 cycles.
- The slice is combinational. Each nibble has exactly one cycle for slice propagation, with no wait states.

## Structure
- The shared package (`alu_pkg`) holds:
  - the state enum `nsa_state_t` {IDLE, RUN, DONE};
  - the constant `ALU_A_MINUS_B = 5'b01001` (the `{M,S}` code);
  - the nibble width constant 4.
- The counter width is `$clog2(NIB)`, local to the block.
- A single module with no sub-modules. The slice (`mc10181`) is instantiated by the parent or bench, not inside this block.

## Test plan
Benches use a real `mc10181` wired to the slice* ports.

- **Simple subtract:** `op`=01001, `cin`=1, a=5, b=3, `start` pulse -> `busy` high for 9 cycles, `done` at T0+10, `result`=2, `cout`=1.
- **Borrow ripple:** a=36'h000000010, b=1, `op`=01001, `cin`=1 -> `result`=36'h00000000F, `cout`=1.
  - The nibble-0 capture shows `sliceCOUT`=0, and `sliceCIN`=0 is driven for nibble 1.
- **Full wrap:** a=0, b=1 -> `result`=36'hFFFFFFFFF, `cout`=0.
- **Back-to-back:**
  - Second `start` held during the DONE cycle -> RUN on the next cycle and second `done` exactly 10 cycles later.
  - `start` pulses during RUN are ignored.
- **Reset mid-op:** `reset` at cycle T0+4 -> next cycle: IDLE, `busy`=0, `result`=0, `cout`=0, no `done` pulse. A subsequent op completes correctly.
- **Sweep:** random a/b over 1000 ops with `op`=01001, `cin`=1 -> `result` == (a−b) mod 2^36 on every `done`.
